// File: rtl/icache_param_if.sv
// Fetch and refill signal bundle between the instruction cache and its
// environment (CPU fetch side plus the AXI refill engine).
interface icache_param_if #(
  parameter int LINE_WORDS = 8
);
  logic                       rd_req;
  logic [31:0]                addr;
  logic                       miss;
  logic [31:0]                rd_data;
  logic                       inv_req;
  logic                       icache_rd_req;
  logic [31:0]                icache_addr;
  logic                       icache_gnt;
  logic [32*LINE_WORDS-1:0]   icache_data;
  logic [31:0]                hit_cnt;
  logic [31:0]                miss_cnt;

  // Environment side: issues fetches, invalidates and refill grants.
  modport master (
    output rd_req, addr, inv_req, icache_gnt, icache_data,
    input  miss, rd_data, icache_rd_req, icache_addr, hit_cnt, miss_cnt
  );

  // Cache side.
  modport slave (
    input  rd_req, addr, inv_req, icache_gnt, icache_data,
    output miss, rd_data, icache_rd_req, icache_addr, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/icache_param.sv
// Parameterised set-associative instruction cache with tree-PLRU
// replacement, single-cycle lookup, blocking line refill and a
// set-by-set invalidation sweep.
module icache_param #(
  parameter int WAYS       = 4,
  parameter int SETS       = 128,
  parameter int LINE_WORDS = 8
) (
  input logic           clk,
  input logic           rst,
  icache_param_if.slave bus
);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WSEL_W + 2;
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int LINE_W = 32 * LINE_WORDS;

  typedef enum logic [1:0] {RSET, IDLE, REQ} state_t;

  state_t            state;
  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
  logic [LINE_W-1:0] data_mem [WAYS][SETS];
  logic [WAYS-1:0]   valid    [SETS];
  logic [WAYS-2:0]   plru     [SETS];
  logic [IDX_W-1:0]  sweep_cnt;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              inv_pend;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  logic [TAG_W-1:0]  cur_tag;
  logic [IDX_W-1:0]  cur_idx;
  logic [WSEL_W-1:0] cur_wsel;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic              lookup;
  logic              do_hit;
  logic              do_miss;
  logic              addr_unused;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Walk the tree from the root: a set bit steers toward the upper half.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
    int node;
    node = 1;
    for (int l = 0; l < WAY_W; l++) node = 2 * node + int'(bits[node-1]);
    return WAY_W'(node - WAYS);
  endfunction

  // Make every node on the path to 'way' point to the opposite subtree.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_W-1:0] way);
    logic [WAYS-2:0] nb;
    int node;
    nb   = bits;
    node = 1;
    for (int l = 0; l < WAY_W; l++) begin
      nb[node-1] = ~way[WAY_W-1-l];
      node       = 2 * node + int'(way[WAY_W-1-l]);
    end
    return nb;
  endfunction

  assign cur_tag     = bus.addr[31 -: TAG_W];
  assign cur_idx     = bus.addr[OFF_W +: IDX_W];
  assign cur_wsel    = bus.addr[2 +: WSEL_W];
  assign addr_unused = ^bus.addr[1:0];

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[cur_idx][w] && tag_mem[w][cur_idx] == cur_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim for the pending refill: lowest invalid way, otherwise PLRU.
  always_comb begin
    victim = plru_victim(plru[req_idx]);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[req_idx][w]) victim = WAY_W'(w);
    end
  end

  // An invalidate in the same cycle as a miss wins; that miss is not issued.
  assign lookup  = (state == IDLE) && !rst && bus.rd_req;
  assign do_hit  = lookup && hit;
  assign do_miss = lookup && !hit && !bus.inv_req;

  assign bus.miss          = rst || (state != IDLE) || (bus.rd_req && !hit);
  assign bus.rd_data       = do_hit ? data_mem[hit_way][cur_idx][cur_wsel*32 +: 32] : 32'd0;
  assign bus.icache_rd_req = !rst && ((state == REQ) || do_miss);
  assign bus.icache_addr   = (state == REQ) ? {req_tag, req_idx, {OFF_W{1'b0}}} :
                             do_miss        ? {cur_tag, cur_idx, {OFF_W{1'b0}}} : 32'd0;
  assign bus.hit_cnt       = hit_cnt;
  assign bus.miss_cnt      = miss_cnt;

  // Control FSM: invalidation sweep, lookup bookkeeping and refill completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RSET;
      sweep_cnt <= '0;
      inv_pend  <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      case (state)
        RSET: begin
          valid[sweep_cnt] <= '0;
          plru[sweep_cnt]  <= '0;
          if (sweep_cnt == IDX_W'(SETS - 1)) begin
            sweep_cnt <= '0;
            state     <= IDLE;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (do_hit) begin
            hit_cnt       <= sat_inc(hit_cnt);
            plru[cur_idx] <= plru_touch(plru[cur_idx], hit_way);
          end
          if (bus.inv_req) begin
            state <= RSET;
          end else if (do_miss) begin
            req_tag  <= cur_tag;
            req_idx  <= cur_idx;
            miss_cnt <= sat_inc(miss_cnt);
            state    <= REQ;
          end
        end
        REQ: begin
          if (bus.inv_req) inv_pend <= 1'b1;
          if (bus.icache_gnt) begin
            valid[req_idx][victim] <= 1'b1;
            plru[req_idx]          <= plru_touch(plru[req_idx], victim);
            inv_pend               <= 1'b0;
            state                  <= (inv_pend || bus.inv_req) ? RSET : IDLE;
          end
        end
        default: state <= RSET;
      endcase
    end
  end

  // Line storage: written only when a live refill is granted.
  always_ff @(posedge clk) begin
    if (!rst && state == REQ && bus.icache_gnt) begin
      tag_mem[victim][req_idx]  <= req_tag;
      data_mem[victim][req_idx] <= bus.icache_data;
    end
  end
endmodule

// File: tb/tb_icache_param.sv
// Testbench for icache_param: directed scenarios followed by random fetch
// traffic, every observation compared with a behavioural cache model.
module tb_icache_param;
  localparam int WAYS = 4;
  localparam int SETS = 128;
  localparam int LW   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_param_if #(.LINE_WORDS(LW)) bus();

  icache_param #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: per set/way contents plus a PLRU tree kept as heap nodes 1..WAYS-1.
  bit          m_valid [SETS][WAYS];
  logic [19:0] m_tag   [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS][LW];
  bit          m_plru  [SETS][WAYS];
  int unsigned m_hit;
  int unsigned m_miss;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_plru[s][w]  = 1'b0;
      end
  endfunction

  // Range halving: node bit 1 means the replacement candidate lies in the upper half.
  function automatic int m_victim(input int s);
    int lo, n, node;
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
    lo = 0; n = WAYS; node = 1;
    while (n > 1) begin
      if (m_plru[s][node]) begin lo = lo + n / 2; node = 2 * node + 1; end
      else node = 2 * node;
      n = n / 2;
    end
    return lo;
  endfunction

  function automatic void m_touch(input int s, input int way);
    int lo, n, node;
    bit upper;
    lo = 0; n = WAYS; node = 1;
    while (n > 1) begin
      upper = (way >= lo + n / 2);
      m_plru[s][node] = !upper;
      if (upper) begin lo = lo + n / 2; node = 2 * node + 1; end
      else node = 2 * node;
      n = n / 2;
    end
  endfunction

  task automatic sweep_check(input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      #1;
      if (bus.miss !== 1'b1 || bus.icache_rd_req !== 1'b0) bad++;
      tick();
    end
    check("sweep_stall", bad, 0);
  endtask

  // One fetch, predicted by the model; on a miss the refill is granted after 'lat' REQ cycles.
  task automatic access(input logic [31:0] a, input int lat, input bit wander,
                        input logic [31:0] waddr, input bit wrd, input bit inv_mid,
                        input logic [31:0] base);
    int s, w, v;
    logic [19:0] t;
    bit hit;
    logic [31:0] line_a;
    logic [32*LW-1:0] line;
    s = int'(a[11:5]); t = a[31:12]; w = int'(a[4:2]); line_a = {a[31:5], 5'b0};
    line = '0;
    bus.rd_req = 1'b1; bus.addr = a;
    #1;
    hit = 1'b0; v = 0;
    for (int i = 0; i < WAYS; i++)
      if (m_valid[s][i] && m_tag[s][i] == t) begin hit = 1'b1; v = i; end
    if (hit) begin
      check("hit_miss", bus.miss, 0);
      check("hit_data", bus.rd_data, m_data[s][v][w]);
      m_touch(s, v);
      m_hit++;
      tick();
    end else begin
      check("miss_flag", bus.miss, 1);
      check("miss_rdreq", bus.icache_rd_req, 1);
      check("miss_addr", bus.icache_addr, line_a);
      m_miss++;
      tick();
      for (int i = 0; i <= lat; i++) begin
        if (i == 0 && wander) begin bus.addr = waddr; bus.rd_req = wrd; end
        bus.inv_req = inv_mid && (i == 0);
        if (i == lat) begin
          for (int k = 0; k < LW; k++) line[32*k +: 32] = (base != 0) ? base + k : $urandom;
          bus.icache_gnt  = 1'b1;
          bus.icache_data = line;
        end
        #1;
        check("req_stall", bus.miss, 1);
        check("req_rdreq", bus.icache_rd_req, 1);
        check("req_addr", bus.icache_addr, line_a);
        tick();
        bus.icache_gnt = 1'b0;
        bus.inv_req    = 1'b0;
      end
      v = m_victim(s);
      m_valid[s][v] = 1'b1;
      m_tag[s][v]   = t;
      for (int k = 0; k < LW; k++) m_data[s][v][k] = line[32*k +: 32];
      m_touch(s, v);
      if (inv_mid) begin
        sweep_check(SETS);
        model_clear();
      end
    end
    bus.rd_req = 1'b0;
    check("hit_cnt", bus.hit_cnt, m_hit);
    check("miss_cnt", bus.miss_cnt, m_miss);
  endtask

  initial begin
    logic [31:0] a;
    logic [19:0] tags [7];
    logic [6:0]  sets [3];
    tags = '{20'h1FC00, 20'h00010, 20'h00011, 20'h00012, 20'h00013, 20'h00014, 20'h00015};
    sets = '{7'd0, 7'd1, 7'd127};

    bus.rd_req = 1'b0; bus.addr = '0; bus.inv_req = 1'b0;
    bus.icache_gnt = 1'b0; bus.icache_data = '0;
    model_clear(); m_hit = 0; m_miss = 0;

    // Reset state.
    tick(); tick(); #1;
    check("rst_miss", bus.miss, 1);
    check("rst_rdreq", bus.icache_rd_req, 0);
    check("rst_hitcnt", bus.hit_cnt, 0);
    check("rst_misscnt", bus.miss_cnt, 0);
    rst = 1'b0;
    bus.rd_req = 1'b1; bus.addr = 32'h1FC0_0000;
    sweep_check(SETS);

    // First miss; address wanders during REQ, refill still targets the original line.
    access(32'h1FC0_0000, 2, 1'b1, 32'h0000_2000, 1'b1, 1'b0, 32'h100);
    bus.rd_req = 1'b1; bus.addr = 32'h1FC0_0014; #1;
    check("rd_data_105", bus.rd_data, 32'h105);
    access(32'h1FC0_0014, 0, 1'b0, 0, 1'b0, 1'b0, 0);
    check("hit_cnt_one", bus.hit_cnt, 1);
    check("miss_cnt_one", bus.miss_cnt, 1);
    access(32'h0000_2000, 1, 1'b0, 0, 1'b0, 1'b0, 0);

    // Idle cycle leaves counters alone.
    bus.rd_req = 1'b0; bus.addr = 32'h1FC0_0000; #1;
    check("idle_miss", bus.miss, 0);
    tick();
    check("idle_hitcnt", bus.hit_cnt, m_hit);

    // Invalidate in IDLE: full sweep, then previously cached line misses.
    bus.inv_req = 1'b1; #1;
    check("inv_idle_miss", bus.miss, 0);
    tick();
    bus.inv_req = 1'b0;
    sweep_check(SETS);
    model_clear();
    access(32'h1FC0_0000, 0, 1'b0, 0, 1'b0, 1'b0, 0);

    // Five tags into set 0, hit the way-0 line, sixth tag must spare it.
    for (int i = 1; i < 5; i++) access({tags[i], 12'h000}, 1, 1'b0, 0, 1'b0, 1'b0, 0);
    access({tags[4], 12'h004}, 0, 1'b0, 0, 1'b0, 1'b0, 0);
    access({tags[5], 12'h000}, 1, 1'b0, 0, 1'b0, 1'b0, 0);
    bus.rd_req = 1'b1; bus.addr = {tags[4], 12'h008}; #1;
    check("plru_keep_way0", bus.miss, 0);
    access({tags[4], 12'h008}, 0, 1'b0, 0, 1'b0, 1'b0, 0);

    // Invalidate during REQ: fill completes, then the sweep runs.
    access(32'h3000_0040, 1, 1'b0, 0, 1'b0, 1'b1, 0);
    access(32'h3000_0040, 0, 1'b0, 0, 1'b0, 1'b0, 0);

    // Reset one cycle into a refill; a late grant must write nothing.
    a = 32'h4000_0020;
    bus.rd_req = 1'b1; bus.addr = a; #1;
    check("abort_rdreq", bus.icache_rd_req, 1);
    tick();
    rst = 1'b1; bus.rd_req = 1'b0;
    tick();
    rst = 1'b0;
    bus.icache_gnt = 1'b1; bus.icache_data = {LW{32'hDEAD_BEEF}};
    #1;
    check("abort_rdreq_off", bus.icache_rd_req, 0);
    check("abort_hitcnt", bus.hit_cnt, 0);
    check("abort_misscnt", bus.miss_cnt, 0);
    tick();
    bus.icache_gnt = 1'b0;
    sweep_check(SETS - 1);
    model_clear(); m_hit = 0; m_miss = 0;
    access(a, 0, 1'b0, 0, 1'b0, 1'b0, 0);

    // Random traffic over a few conflicting sets.
    for (int n = 0; n < 200; n++) begin
      a = {tags[$urandom_range(0, 6)], sets[$urandom_range(0, 2)], 3'($urandom_range(0, 7)), 2'b00};
      if ($urandom_range(0, 4) == 0) begin
        bus.rd_req = 1'b0; bus.addr = $urandom; #1;
        check("rnd_idle_miss", bus.miss, 0);
        tick();
      end
      access(a, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom,
             1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0), 0);
    end

    check("final_hitcnt", bus.hit_cnt, m_hit);
    check("final_misscnt", bus.miss_cnt, m_miss);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
